ci_master: RTL
==============

# ci_master

Initiator side of the team's custom-instruction handshake (dataa/datab/start/done/result). It accepts an arithmetic request (multiply, divide, remainder) from game logic and drives the matching slave unit (`mul`, `div` or `resto`). It waits for that slave's `done`, captures the result, and returns it through a valid/ready response port. A timeout guards against a slave that never completes.

## Interface
- `TIMEOUT`, 128: max cycles spent in WAIT before aborting; ≥2.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_op` in 2: 0=mul, 1=div, 2=resto, 3=illegal.
- `req_a` in 32: operand A (dividend for div/resto).
- `req_b` in 32: operand B (divisor for div/resto).
- `resp_valid` out 1: response present.
- `resp_ready` in 1: response consumed.
- `resp_result` out 32: captured slave result; 0 on error or timeout.
- `resp_err` out 1: illegal opcode.
- `resp_timeout` out 1: slave did not finish within `TIMEOUT` cycles.
- `ci_dataa` out 32: operand A to all slaves.
- `ci_datab` out 32: operand B to all slaves.
- `ci_clk_en` out 1: constant 1.
- `ci_reset` out 1: slave reset = `reset` OR (state==CLR).
- `ci_start` out 3: one-hot start pulse; bit n selects slave n.
- `ci_done` in 3: per-slave done (bit 0 mul, 1 div, 2 resto).
- `ci_result0` in 32: mul result.
- `ci_result1` in 32: div result.
- `ci_result2` in 32: resto result.

## Operation
- States: IDLE, CLR, START, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid`, register op, A and B. Next state is RESP with `resp_err`=1 if op==3, else CLR.
- CLR: `ci_reset`=1 for exactly 1 cycle. Goes to START.
- START: `ci_start[op]`=1 for exactly 1 cycle, other bits 0. Clears the WAIT counter. Goes to WAIT.
- WAIT: counter increments each cycle.
  - `ci_done[op]`=1: capture `ci_result<op>` into `resp_result`, go to RESP.
  - Else if counter==`TIMEOUT`-1: `resp_result`=0, `resp_timeout`=1, go to RESP.
  - `done` and timeout in the same cycle: `done` wins.
- RESP: `resp_valid`=1. Result and flags held stable until `resp_valid && resp_ready`, then go to IDLE.
- `ci_dataa`/`ci_datab` are driven from the operand registers and stay stable from CLR through RESP. They change only on acceptance.
- Only the selected slave's `done`/result is observed. Other `ci_done` bits are ignored, as is any `done` during CLR or START.
- No arithmetic is done in this block. Results pass through bit-exact.
- Reset, including mid-operation: state goes to IDLE and the counter clears. Outputs take reset values and any in-flight request is dropped; `ci_reset`=1 propagates reset to the slaves.
- Reset values:
  - `req_ready`=0 during reset, 1 the cycle after.
  - `resp_valid`=0, `resp_result`=0, `resp_err`=0, `resp_timeout`=0.
  - `ci_start`=0, `ci_dataa`=0, `ci_datab`=0.
  - `ci_reset`=1, `ci_clk_en`=1.

## Timing
- All outputs are registered or decoded from state only. No combinational path from `ci_done` or `req_valid` to any output.
- Request accepted at edge E0. CLR runs in cycle E0+1, START in E0+2, WAIT from E0+3.
- `ci_done[op]` sampled high at WAIT cycle k (k=0 is first) → `resp_valid` high from E0+4+k.
- Minimum latency is 4 cycles to `resp_valid`.
- Illegal op → `resp_valid` in E0+1.
- Timeout → `resp_valid` at E0+3+`TIMEOUT`.
- Back-to-back: after response handshake at edge R, `req_ready`=1 in cycle R+1. Throughput is at most 1 request per 5 cycles.

## Test plan
- Mul, op=0, A=7, B=6; slave model raises `done[0]` 3 cycles after start with result 42 → `resp_result`=42, flags 0. `ci_start`=3'b001 for one cycle. `resp_valid` exactly 4+2 cycles after accept.
- Div then resto, back-to-back, A=100, B=7; real `div`/`resto` instances → 14 then 2. `req_ready` low between accept and response handshake. No start pulse to the other slaves.
- Illegal op=3, A=1, B=1 → `resp_valid` the next cycle, `resp_err`=1, `resp_result`=0, `ci_start` never asserted.
- Timeout: `TIMEOUT`=8, `ci_done` tied 0 → `resp_timeout`=1, `resp_result`=0, `resp_valid` at E0+11. `ci_done[1]` high in that final WAIT cycle → normal result, no timeout.
- Backpressure plus stray done: hold `resp_ready`=0 for 10 cycles → result stable, no new accept. Pulse a non-selected `ci_done` bit during WAIT → ignored.
- Reset in WAIT → next cycle IDLE, `resp_valid`=0, `ci_reset`=1 during reset. A fresh mul 3×5 afterwards returns 15.

Source files
------------

// File: rtl/ci_master_if.sv
// Request/response port plus custom-instruction bus between ci_master and its slaves.
// Latency: none (wires only). Backpressure: valid/ready on both the request and response sides.
interface ci_master_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        resp_err;
  logic        resp_timeout;
  logic [31:0] ci_dataa;
  logic [31:0] ci_datab;
  logic        ci_clk_en;
  logic        ci_reset;
  logic [2:0]  ci_start;
  logic [2:0]  ci_done;
  logic [31:0] ci_result0;
  logic [31:0] ci_result1;
  logic [31:0] ci_result2;

  modport master (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    input  ci_done, ci_result0, ci_result1, ci_result2,
    output req_ready, resp_valid, resp_result, resp_err, resp_timeout,
    output ci_dataa, ci_datab, ci_clk_en, ci_reset, ci_start
  );

  modport slave (
    output req_valid, req_op, req_a, req_b, resp_ready,
    output ci_done, ci_result0, ci_result1, ci_result2,
    input  req_ready, resp_valid, resp_result, resp_err, resp_timeout,
    input  ci_dataa, ci_datab, ci_clk_en, ci_reset, ci_start
  );
endinterface

// File: rtl/ci_master.sv
// Custom-instruction initiator: clear, start and wait on the selected slave (mul/div/resto); latency >= 4 cycles.
// One request in flight: req_ready only in IDLE, and the response is held until resp_ready.
module ci_master #(
  parameter int TIMEOUT = 128
) (
  input logic         clk,
  input logic         reset,
  ci_master_if.master bus
);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, CLR, START, WAIT, RESP} state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [31:0]     a_q, a_d, b_q, b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      start_q, start_d;
  logic [31:0]     result_q, result_d;
  logic            err_q, err_d;
  logic            tmo_q, tmo_d;
  logic            done_sel;
  logic [31:0]     result_sel;

  // Only the addressed slave is observed; other done/result lines are don't-care.
  always_comb begin
    done_sel   = 1'b0;
    result_sel = 32'd0;
    case (op_q)
      2'd0:    begin done_sel = bus.ci_done[0]; result_sel = bus.ci_result0; end
      2'd1:    begin done_sel = bus.ci_done[1]; result_sel = bus.ci_result1; end
      2'd2:    begin done_sel = bus.ci_done[2]; result_sel = bus.ci_result2; end
      default: begin done_sel = 1'b0;           result_sel = 32'd0;          end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    start_d  = 3'b000;
    result_d = result_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_d     = bus.req_op;
          a_d      = bus.req_a;
          b_d      = bus.req_b;
          result_d = 32'd0;
          err_d    = (bus.req_op == 2'd3);
          tmo_d    = 1'b0;
          state_d  = (bus.req_op == 2'd3) ? RESP : CLR;
        end
      end
      CLR: begin
        start_d = 3'b001 << op_q;
        state_d = START;
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // A done arriving on the last allowed cycle still counts as success.
        if (done_sel) begin
          result_d = result_sel;
          state_d  = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          result_d = 32'd0;
          tmo_d    = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= 2'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      cnt_q    <= '0;
      start_q  <= 3'b000;
      result_q <= 32'd0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      result_q <= result_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  assign bus.req_ready    = (state_q == IDLE) && !reset;
  assign bus.resp_valid   = (state_q == RESP);
  assign bus.resp_result  = result_q;
  assign bus.resp_err     = err_q;
  assign bus.resp_timeout = tmo_q;
  assign bus.ci_dataa     = a_q;
  assign bus.ci_datab     = b_q;
  assign bus.ci_clk_en    = 1'b1;
  assign bus.ci_reset     = reset || (state_q == CLR);
  assign bus.ci_start     = start_q;
endmodule
